snake_movement_controller: RTL and testbench

SNAKE_MOVEMENT_CONTROLLER -- requirements
Module: snake_movement_controller

---
 rtl/snake_movement_controller_if.sv | 27 ++
 rtl/snake_movement_controller.sv | 167 ++++++++++++++++
 tb/tb_snake_movement_controller.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_movement_controller_if.sv
// Control bundle from the game logic into the snake movement controller.
// The game logic drives it (master) and the controller samples it (slave).
interface snake_movement_controller_if #(
  parameter int COORD_WIDTH  = 10,
  parameter int LENGTH_WIDTH = 6
);
  logic                    start;
  logic                    move_tick;
  logic                    dir_valid;
  logic [1:0]              dir_in;
  logic                    grow;
  logic                    respawn_valid;
  logic [COORD_WIDTH-1:0]  respawn_x;
  logic [COORD_WIDTH-1:0]  respawn_y;
  logic [LENGTH_WIDTH-1:0] respawn_length;
  logic [2:0]              lives_in;

  modport master (
    output start, move_tick, dir_valid, dir_in, grow,
           respawn_valid, respawn_x, respawn_y, respawn_length, lives_in
  );

  modport slave (
    input  start, move_tick, dir_valid, dir_in, grow,
           respawn_valid, respawn_x, respawn_y, respawn_length, lives_in
  );
endinterface

// File: rtl/snake_movement_controller.sv
// Snake movement controller: game FSM, direction staging, body shift
// register, growth and respawn handling. Coordinates wrap modulo
// 2^COORD_WIDTH; bounds checking is left to the collision stage.
module snake_movement_controller #(
  parameter int COORD_WIDTH  = 10,
  parameter int MAX_LENGTH   = 63,
  parameter int LENGTH_WIDTH = 6,
  parameter int START_X      = 32,
  parameter int START_Y      = 24
) (
  input  logic                                   clk,
  input  logic                                   reset,
  snake_movement_controller_if.slave             ctrl,
  output logic [COORD_WIDTH-1:0]                 head_x,
  output logic [COORD_WIDTH-1:0]                 head_y,
  output logic [(MAX_LENGTH+1)*COORD_WIDTH-1:0]  body_x,
  output logic [(MAX_LENGTH+1)*COORD_WIDTH-1:0]  body_y,
  output logic [LENGTH_WIDTH-1:0]                snake_length,
  output logic                                   moved,
  output logic [1:0]                             state
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RUN       = 2'b01,
    GAME_OVER = 2'b10
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [COORD_WIDTH-1:0]  SPAWN_X = COORD_WIDTH'(START_X);
  localparam logic [COORD_WIDTH-1:0]  SPAWN_Y = COORD_WIDTH'(START_Y);
  localparam logic [LENGTH_WIDTH-1:0] LEN_MAX = LENGTH_WIDTH'(MAX_LENGTH);
  localparam logic [LENGTH_WIDTH-1:0] LEN_ONE = LENGTH_WIDTH'(1);

  state_t                 state_q, state_d;
  logic                   armed;
  logic                   running;
  logic [1:0]             dir, pending_dir;
  logic                   grow_pending;
  logic [COORD_WIDTH-1:0] seg_x [0:MAX_LENGTH];
  logic [COORD_WIDTH-1:0] seg_y [0:MAX_LENGTH];
  logic [COORD_WIDTH-1:0] next_x, next_y;
  logic                   do_step, do_respawn, dir_accept;

  // Same axis, opposite sense.
  function automatic logic is_reverse(input logic [1:0] req, input logic [1:0] cur);
    return (req[1] == cur[1]) && (req[0] != cur[0]);
  endfunction

  // Cleared by reset and set on the first edge after release, so that edge
  // makes no update and a step in flight at reset is fully discarded.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     state_q <= IDLE;
    else if (armed) state_q <= state_d;
  end

  // FSM next-state logic.
  // NOTE: default assignment first keeps combinational blocks latch-free.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (ctrl.start)            state_d = RUN;
      RUN:       if (ctrl.lives_in == 3'd0) state_d = GAME_OVER;
      GAME_OVER: if (ctrl.start)            state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  // FSM outputs: state code and the play-enable that gates the datapath.
  always_comb begin
    state   = state_q;
    running = armed && (state_q == RUN);
  end

  // Step/respawn qualification; respawn wins over a coincident tick and grow.
  // A request is also refused if it reverses the already-accepted pending
  // direction, so a burst like up-then-down cannot turn the head back onto
  // the neck before the tick commits it.
  always_comb begin
    do_respawn = running && ctrl.respawn_valid;
    do_step    = running && ctrl.move_tick && !ctrl.respawn_valid;
    dir_accept = ctrl.dir_valid
              && !is_reverse(ctrl.dir_in, dir)
              && !is_reverse(ctrl.dir_in, pending_dir);
  end

  // Next head position one unit along the pending direction (wrapping).
  always_comb begin
    next_x = seg_x[0];
    next_y = seg_y[0];
    case (pending_dir)
      DIR_UP:    next_y = seg_y[0] - COORD_WIDTH'(1);
      DIR_DOWN:  next_y = seg_y[0] + COORD_WIDTH'(1);
      DIR_LEFT:  next_x = seg_x[0] - COORD_WIDTH'(1);
      DIR_RIGHT: next_x = seg_x[0] + COORD_WIDTH'(1);
      default:   ;
    endcase
  end

  // Movement datapath: body shift, growth, direction staging, respawn.
  // NOTE: the segment array is reset on purpose; every segment must read as the spawn point.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= MAX_LENGTH; i++) begin
        seg_x[i] <= SPAWN_X;
        seg_y[i] <= SPAWN_Y;
      end
      snake_length <= LEN_ONE;
      dir          <= DIR_RIGHT;
      pending_dir  <= DIR_RIGHT;
      grow_pending <= 1'b0;
      moved        <= 1'b0;
    end else begin
      moved <= do_step || do_respawn;
      if (do_respawn) begin
        for (int i = 0; i <= MAX_LENGTH; i++) begin
          seg_x[i] <= ctrl.respawn_x;
          seg_y[i] <= ctrl.respawn_y;
        end
        snake_length <= (ctrl.respawn_length == '0) ? LEN_ONE : ctrl.respawn_length;
        dir          <= DIR_RIGHT;
        pending_dir  <= DIR_RIGHT;
        grow_pending <= 1'b0;
      end else if (running) begin
        if (do_step) begin
          dir <= pending_dir;
          for (int i = 1; i <= MAX_LENGTH; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= next_x;
          seg_y[0] <= next_y;
          if ((grow_pending || ctrl.grow) && (snake_length != LEN_MAX))
            snake_length <= snake_length + LEN_ONE;
          grow_pending <= 1'b0;
        end else if (ctrl.grow) begin
          grow_pending <= 1'b1;
        end
        if (dir_accept) pending_dir <= ctrl.dir_in;
      end
    end
  end

  // Flatten the segment array onto the body buses.
  always_comb begin
    head_x = seg_x[0];
    head_y = seg_y[0];
    body_x = '0;
    body_y = '0;
    for (int i = 0; i <= MAX_LENGTH; i++) begin
      body_x[COORD_WIDTH*i +: COORD_WIDTH] = seg_x[i];
      body_y[COORD_WIDTH*i +: COORD_WIDTH] = seg_y[i];
    end
  end

endmodule

// File: tb/tb_snake_movement_controller.sv
// Scoreboard bench for snake_movement_controller: each step/respawn pushes
// its expected head, segment 1, length and arrival cycle; a monitor pops and
// compares whenever moved is high. State and freeze checks are direct.
module tb_snake_movement_controller;

  localparam int CW = 10;
  localparam int LW = 6;
  localparam int ML = 63;

  logic                     clk;
  logic                     reset;
  logic [CW-1:0]            head_x, head_y;
  logic [(ML+1)*CW-1:0]     body_x, body_y;
  logic [LW-1:0]            snake_length;
  logic                     moved;
  logic [1:0]               state;

  snake_movement_controller_if #(.COORD_WIDTH(CW), .LENGTH_WIDTH(LW)) bus ();

  snake_movement_controller #(
    .COORD_WIDTH(CW), .MAX_LENGTH(ML), .LENGTH_WIDTH(LW), .START_X(32), .START_Y(24)
  ) dut (
    .clk(clk), .reset(reset), .ctrl(bus),
    .head_x(head_x), .head_y(head_y), .body_x(body_x), .body_y(body_y),
    .snake_length(snake_length), .moved(moved), .state(state)
  );

  typedef struct {
    string         name;
    int            cyc;
    logic [CW-1:0] hx, hy, s1x, s1y;
    logic [LW-1:0] len;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish (got timeout, required finish)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Called at posedge+#1, before the edge that performs the step.
  task automatic expect_move(input string name, input int hx, input int hy,
                             input int s1x, input int s1y, input int len);
    exp_t x;
    x.name = name;
    x.cyc  = cyc + 1;
    x.hx   = CW'(hx);
    x.hy   = CW'(hy);
    x.s1x  = CW'(s1x);
    x.s1y  = CW'(s1y);
    x.len  = LW'(len);
    q.push_back(x);
  endtask

  // One clock: inputs set beforehand are sampled, then pulses clear.
  task automatic step_clk();
    @(posedge clk);
    #1;
    bus.start         = 1'b0;
    bus.move_tick     = 1'b0;
    bus.dir_valid     = 1'b0;
    bus.grow          = 1'b0;
    bus.respawn_valid = 1'b0;
  endtask

  // Monitor: every moved pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (moved) begin
      check("moved_expected", (q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.name, ".cycle"},  cyc,                e.cyc);
        check({e.name, ".head_x"}, head_x,             e.hx);
        check({e.name, ".head_y"}, head_y,             e.hy);
        check({e.name, ".seg1_x"}, body_x[2*CW-1:CW],  e.s1x);
        check({e.name, ".seg1_y"}, body_y[2*CW-1:CW],  e.s1y);
        check({e.name, ".length"}, snake_length,       e.len);
      end
    end
  end

  initial begin
    int bad;
    reset              = 1'b0;
    bus.start          = 1'b0;
    bus.move_tick      = 1'b0;
    bus.dir_valid      = 1'b0;
    bus.dir_in         = 2'b00;
    bus.grow           = 1'b0;
    bus.respawn_valid  = 1'b0;
    bus.respawn_x      = '0;
    bus.respawn_y      = '0;
    bus.respawn_length = '0;
    bus.lives_in       = 3'd3;

    repeat (2) @(posedge clk);
    #1;
    check("reset.state",  state,        0);
    check("reset.head_x", head_x,       32);
    check("reset.head_y", head_y,       24);
    check("reset.length", snake_length, 1);
    check("reset.moved",  moved,        0);

    reset = 1'b1;
    step_clk();
    step_clk();
    check("idle.state", state, 0);

    bus.start = 1'b1; step_clk();
    check("start.state", state, 1);

    // Three plain ticks heading right.
    for (int k = 1; k <= 3; k++) begin
      expect_move($sformatf("tick%0d", k), 32 + k, 24, 31 + k, 24, 1);
      bus.move_tick = 1'b1; step_clk();
      step_clk();
    end
    check("after_ticks.head_x", head_x, 35);

    // Left (reverse) ignored; up accepted; down (reverse of up) ignored.
    bus.dir_valid = 1'b1; bus.dir_in = 2'b10; step_clk();
    bus.dir_valid = 1'b1; bus.dir_in = 2'b00; step_clk();
    bus.dir_valid = 1'b1; bus.dir_in = 2'b01; step_clk();
    expect_move("dir_up", 35, 23, 35, 24, 1);
    bus.move_tick = 1'b1; step_clk();
    step_clk();

    // Grow then two ticks.
    bus.grow = 1'b1; step_clk();
    expect_move("grow_tick1", 35, 22, 35, 23, 2);
    bus.move_tick = 1'b1; step_clk();
    step_clk();
    expect_move("grow_tick2", 35, 21, 35, 22, 2);
    bus.move_tick = 1'b1; step_clk();
    step_clk();

    // Grow and tick together.
    expect_move("grow_same_cycle", 35, 20, 35, 21, 3);
    bus.grow = 1'b1; bus.move_tick = 1'b1; step_clk();
    step_clk();

    // 63 grows with ticks: length saturates, y wraps through 0 to 1023.
    for (int k = 1; k <= 63; k++) begin
      expect_move($sformatf("sat%0d", k), 35, (20 - k) & 1023, 35, (21 - k) & 1023,
                  (3 + k > 63) ? 63 : 3 + k);
      bus.grow = 1'b1; bus.move_tick = 1'b1; step_clk();
    end
    step_clk();
    check("saturate.length", snake_length, 63);

    // Respawn with zero length, coincident tick and grow.
    expect_move("respawn", 10, 12, 10, 12, 1);
    bus.respawn_valid = 1'b1; bus.respawn_x = 10'd10; bus.respawn_y = 10'd12;
    bus.respawn_length = 6'd0; bus.move_tick = 1'b1; bus.grow = 1'b1;
    step_clk();
    step_clk();
    bad = 0;
    for (int i = 0; i <= ML; i++)
      if (body_x[CW*i +: CW] !== 10'd10 || body_y[CW*i +: CW] !== 10'd12) bad++;
    check("respawn.segments_off_point", bad, 0);
    expect_move("respawn_then_right", 11, 12, 10, 12, 1);
    bus.move_tick = 1'b1; step_clk();
    step_clk();

    // Respawn at x=0 with length 4, turn up, then left across x=0.
    expect_move("respawn2", 0, 5, 0, 5, 4);
    bus.respawn_valid = 1'b1; bus.respawn_x = 10'd0; bus.respawn_y = 10'd5;
    bus.respawn_length = 6'd4; step_clk();
    step_clk();
    bus.dir_valid = 1'b1; bus.dir_in = 2'b00; step_clk();
    expect_move("up_at_x0", 0, 4, 0, 5, 4);
    bus.move_tick = 1'b1; step_clk();
    step_clk();
    bus.dir_valid = 1'b1; bus.dir_in = 2'b10; step_clk();
    expect_move("wrap_left", 1023, 4, 0, 4, 4);
    bus.move_tick = 1'b1; step_clk();
    step_clk();

    // Lives exhausted: GAME_OVER, everything frozen, start returns to IDLE.
    bus.lives_in = 3'd0; step_clk();
    bus.lives_in = 3'd3;
    check("game_over.state", state, 2);
    for (int k = 0; k < 3; k++) begin
      bus.move_tick = 1'b1; bus.grow = 1'b1; step_clk();
    end
    bus.respawn_valid = 1'b1; bus.respawn_x = 10'd7; step_clk();
    check("game_over.head_x", head_x,       1023);
    check("game_over.head_y", head_y,       4);
    check("game_over.length", snake_length, 4);
    check("game_over.hold",   state,        2);
    bus.start = 1'b1; step_clk();
    check("game_over_to_idle.state", state, 0);
    bus.move_tick = 1'b1; step_clk();
    check("idle_frozen.head_x", head_x, 1023);
    bus.start = 1'b1; step_clk();
    check("restart.state", state, 1);
    expect_move("restart_tick", 1022, 4, 1023, 4, 4);
    bus.move_tick = 1'b1; step_clk();
    step_clk();

    // Asynchronous reset mid-RUN with a tick pending.
    bus.move_tick = 1'b1;
    reset = 1'b0;
    #2;
    check("async_reset.head_x", head_x,            32);
    check("async_reset.head_y", head_y,            24);
    check("async_reset.seg1_x", body_x[2*CW-1:CW], 32);
    check("async_reset.length", snake_length,      1);
    check("async_reset.state",  state,             0);
    check("async_reset.moved",  moved,             0);
    bus.move_tick = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.start = 1'b1; step_clk();
    check("first_edge_ignored.state", state, 0);
    bus.start = 1'b1; step_clk();
    check("post_reset_start.state", state, 1);
    expect_move("post_reset_tick", 33, 24, 32, 24, 1);
    bus.move_tick = 1'b1; step_clk();
    step_clk();
    step_clk();

    check("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
